// File: rtl/rv32i_prefetch_fetch_stage.sv
// Decoupled RV32I fetch: credit-limited sequential prefetch into a small {pc, instr} queue.
// A redirect flushes the queue at once; still-outstanding responses are squashed by count.
module rv32i_prefetch_fetch_stage #(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          QUEUE_DEPTH     = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_redirect_valid,
   input  logic [31:0]                    i_redirect_pc,
   output logic                           o_imem_req_valid,
   input  logic                           i_imem_req_ready,
   output logic [31:0]                    o_imem_req_addr,
   input  logic                           i_imem_rsp_valid,
   input  logic [31:0]                    i_imem_rsp_data,
   output logic                           o_fetch_valid,
   input  logic                           i_decode_ready,
   output logic [31:0]                    o_fetch_instruction,
   output logic [31:0]                    o_fetch_pc,
   output logic [$clog2(QUEUE_DEPTH):0]   o_queue_count,
   output logic                           o_rsp_error
);

   localparam int QAW = $clog2(QUEUE_DEPTH);
   localparam int CW  = QAW + 1;
   localparam int IW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int OW  = CW + 1;

   localparam logic [OW-1:0] LP_QD    = OW'(QUEUE_DEPTH);
   localparam logic [IW-1:0] LP_MAX   = IW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LP_PLAST = PW'(MAX_OUTSTANDING - 1);
   localparam logic [31:0]   LP_NOP   = 32'h0000_0013;

   logic [31:0]    r_fetch_pc;
   logic [IW-1:0]  r_in_flight;
   logic [IW-1:0]  r_discard;
   logic [CW-1:0]  r_q_count;
   logic [QAW-1:0] r_q_rd_ptr;
   logic [QAW-1:0] r_q_wr_ptr;
   logic [PW-1:0]  r_pcf_rd_ptr;
   logic [PW-1:0]  r_pcf_wr_ptr;
   logic           r_rsp_error;

   logic [31:0]    w_q_pc_arr   [QUEUE_DEPTH];
   logic [31:0]    w_q_data_arr [QUEUE_DEPTH];
   logic [31:0]    w_pcf_arr    [MAX_OUTSTANDING];

   logic [IW-1:0]  w_live;
   logic [OW-1:0]  w_occupancy;
   logic           w_req_valid;
   logic           w_accept;
   logic           w_rsp_hit;
   logic           w_rsp_spur;
   logic           w_rsp_drop;
   logic           w_push;
   logic           w_fetch_valid;
   logic           w_pop;
   logic [31:0]    w_rsp_pc;
   logic [31:0]    w_redirect_target;
   logic [IW-1:0]  w_in_flight_next;
   logic [IW-1:0]  w_discard_next;
   logic [CW-1:0]  w_q_count_next;

   function automatic logic [PW-1:0] f_pcf_inc(input logic [PW-1:0] p);
      return (p == LP_PLAST) ? '0 : p + PW'(1);
   endfunction

   // Credit: every live (non-squashed) request already owns a queue slot, so pushes never overflow.
   assign w_live            = r_in_flight - r_discard;
   assign w_occupancy       = OW'(r_q_count) + OW'(w_live);
   assign w_req_valid       = !i_rst && !i_redirect_valid && (r_in_flight < LP_MAX)
                              && (w_occupancy < LP_QD);
   assign w_accept          = w_req_valid && i_imem_req_ready;
   assign w_rsp_hit         = !i_rst && i_imem_rsp_valid && (r_in_flight != '0);
   assign w_rsp_spur        = !i_rst && i_imem_rsp_valid && (r_in_flight == '0);
   assign w_rsp_drop        = (r_discard != '0);
   assign w_push            = w_rsp_hit && !w_rsp_drop && !i_redirect_valid;
   assign w_fetch_valid     = !i_rst && !i_redirect_valid && (r_q_count != '0);
   assign w_pop             = w_fetch_valid && i_decode_ready;
   assign w_rsp_pc          = w_pcf_arr[r_pcf_rd_ptr];
   assign w_redirect_target = i_redirect_pc & 32'hFFFF_FFFC;

   always_comb begin
      w_in_flight_next = r_in_flight;
      if (w_accept && !w_rsp_hit) begin
         w_in_flight_next = r_in_flight + IW'(1);
      end else if (!w_accept && w_rsp_hit) begin
         w_in_flight_next = r_in_flight - IW'(1);
      end

      // No request is accepted during a redirect, so everything still outstanding is stale.
      w_discard_next = r_discard;
      if (i_redirect_valid) begin
         w_discard_next = w_in_flight_next;
      end else if (w_rsp_hit && w_rsp_drop) begin
         w_discard_next = r_discard - IW'(1);
      end

      w_q_count_next = r_q_count;
      if (i_redirect_valid) begin
         w_q_count_next = '0;
      end else if (w_push && !w_pop) begin
         w_q_count_next = r_q_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_q_count_next = r_q_count - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fetch_pc   <= RESET_PC;
         r_in_flight  <= '0;
         r_discard    <= '0;
         r_q_count    <= '0;
         r_q_rd_ptr   <= '0;
         r_q_wr_ptr   <= '0;
         r_pcf_rd_ptr <= '0;
         r_pcf_wr_ptr <= '0;
         r_rsp_error  <= 1'b0;
      end else begin
         r_in_flight <= w_in_flight_next;
         r_discard   <= w_discard_next;
         r_q_count   <= w_q_count_next;
         if (i_redirect_valid) begin
            r_fetch_pc <= w_redirect_target;
            r_q_rd_ptr <= '0;
            r_q_wr_ptr <= '0;
         end else begin
            if (w_accept) begin
               r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
               r_q_wr_ptr <= r_q_wr_ptr + QAW'(1);
            end
            if (w_pop) begin
               r_q_rd_ptr <= r_q_rd_ptr + QAW'(1);
            end
         end
         // Stale entries stay in the PC FIFO and retire as their responses arrive.
         if (w_accept) begin
            r_pcf_wr_ptr <= f_pcf_inc(r_pcf_wr_ptr);
         end
         if (w_rsp_hit) begin
            r_pcf_rd_ptr <= f_pcf_inc(r_pcf_rd_ptr);
         end
         if (w_rsp_spur) begin
            r_rsp_error <= 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_queue
         logic [31:0] r_pc;
         logic [31:0] r_data;
         always_ff @(posedge i_clk) begin
            if (w_push && (r_q_wr_ptr == QAW'(gi))) begin
               r_pc   <= w_rsp_pc;
               r_data <= i_imem_rsp_data;
            end
         end
         assign w_q_pc_arr[gi]   = r_pc;
         assign w_q_data_arr[gi] = r_data;
      end

      for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_pcf
         logic [31:0] r_pc;
         always_ff @(posedge i_clk) begin
            if (w_accept && (r_pcf_wr_ptr == PW'(gi))) begin
               r_pc <= r_fetch_pc;
            end
         end
         assign w_pcf_arr[gi] = r_pc;
      end
   endgenerate

   assign o_imem_req_valid    = w_req_valid;
   assign o_imem_req_addr     = r_fetch_pc;
   assign o_fetch_valid       = w_fetch_valid;
   assign o_fetch_instruction = w_fetch_valid ? w_q_data_arr[r_q_rd_ptr] : LP_NOP;
   assign o_fetch_pc          = w_fetch_valid ? w_q_pc_arr[r_q_rd_ptr] : 32'h0000_0000;
   assign o_queue_count       = r_q_count;
   assign o_rsp_error         = r_rsp_error;

endmodule
